// File: rtl/demux_pkg.sv
// Shared types and defaults for the nibble demux slice.
// Optional drop counter on demux_estructural is enabled by DEMUX_DROP_CNT_EN.
package demux_pkg;

  typedef enum logic {
    LANE0 = 1'b0,
    LANE1 = 1'b1
  } lane_state_e;

  localparam int unsigned DEFAULT_DATA_WIDTH = 4;
  localparam int unsigned DEFAULT_FIFO_DEPTH = 4;
  localparam logic [7:0]  DROP_CNT_MAX       = 8'd255;

endpackage

// File: rtl/fifo_pair_sync.sv
// Synchronous show-ahead FIFO with registered head, valid and full flags.
// Head holds its last value when the FIFO drains; reads 0 after reset.
module fifo_pair_sync #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             valid,
  output logic             full
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PtrOne  = 1;
  localparam logic [PTR_W:0]   CntOne  = 1;
  localparam logic [PTR_W:0]   CntFull = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             valid_q, full_q;
  logic             pop_en, push_en;

  assign pop_en  = pop & valid_q;
  // A push into a full FIFO only lands if the head leaves on the same edge.
  assign push_en = push & (~full_q | pop_en);

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    head_d   = head_q;
    if (push_en && !pop_en) count_d = count_q + CntOne;
    if (pop_en && !push_en) count_d = count_q - CntOne;
    if (push_en) wr_ptr_d = wr_ptr_q + PtrOne;
    if (pop_en)  rd_ptr_d = rd_ptr_q + PtrOne;
    if (count_d != '0) begin
      // New head is the incoming word when it lands in an empty or emptying FIFO.
      if (count_q == '0 || (count_q == CntOne && pop_en)) head_d = wdata;
      else                                                 head_d = mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
      valid_q  <= 1'b0;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
      valid_q  <= (count_d != '0);
      full_q   <= (count_d == CntFull);
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = head_q;
  assign valid = valid_q;
  assign full  = full_q;

endmodule

// File: rtl/demux_estructural.sv
// Splits the alternating lane-0/lane-1 nibble stream into buffered pairs.
// Define DEMUX_DROP_CNT_EN to add a saturating drop_count output.
module demux_estructural
  import demux_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  valid_in,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] data_out_0,
  output logic [DATA_WIDTH-1:0] data_out_1,
  output logic                  valid_out,
  output logic                  fifo_full,
  output logic                  overflow
`ifdef DEMUX_DROP_CNT_EN
  ,
  output logic [7:0]            drop_count
`endif
);

  lane_state_e             lane_q;
  logic [DATA_WIDTH-1:0]   hold_q;
  logic                    pair_push, drop;
  logic [2*DATA_WIDTH-1:0] pair_wdata, pair_rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      lane_q <= LANE0;
      hold_q <= '0;
    end else if (valid_in) begin
      unique case (lane_q)
        LANE0: begin
          hold_q <= data_in;
          lane_q <= LANE1;
        end
        LANE1: lane_q <= LANE0;
        default: lane_q <= LANE0;
      endcase
    end
  end

  assign pair_push  = valid_in & (lane_q == LANE1);
  assign pair_wdata = {data_in, hold_q};
  assign drop       = pair_push & fifo_full & ~pop;

  fifo_pair_sync #(
    .WIDTH (2 * DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (pair_push),
    .wdata (pair_wdata),
    .pop   (pop),
    .rdata (pair_rdata),
    .valid (valid_out),
    .full  (fifo_full)
  );

  assign data_out_0 = pair_rdata[DATA_WIDTH-1:0];
  assign data_out_1 = pair_rdata[2*DATA_WIDTH-1:DATA_WIDTH];

`ifdef DEMUX_DROP_CNT_EN
  logic [7:0] drop_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      drop_cnt_q <= '0;
    end else if (drop && drop_cnt_q != DROP_CNT_MAX) begin
      drop_cnt_q <= drop_cnt_q + 8'd1;
    end
  end

  assign drop_count = drop_cnt_q;
  assign overflow   = (drop_cnt_q != '0);
`else
  logic overflow_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_q <= 1'b0;
    end else if (drop) begin
      overflow_q <= 1'b1;
    end
  end

  assign overflow = overflow_q;
`endif

endmodule

// File: tb/tb_demux_estructural.sv
// Scoreboard bench for demux_estructural: expected pairs queued on completion,
// compared when the FIFO presents them.
module tb_demux_estructural;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] data_in;
  logic       valid_in;
  logic       pop;
  logic [3:0] data_out_0, data_out_1;
  logic       valid_out, fifo_full, overflow;
`ifdef DEMUX_DROP_CNT_EN
  logic [7:0] drop_count;
`endif

  logic [7:0] exp_q[$];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  demux_estructural dut (
    .clk        (clk),
    .reset      (reset),
    .data_in    (data_in),
    .valid_in   (valid_in),
    .pop        (pop),
    .data_out_0 (data_out_0),
    .data_out_1 (data_out_1),
    .valid_out  (valid_out),
    .fifo_full  (fifo_full),
    .overflow   (overflow)
`ifdef DEMUX_DROP_CNT_EN
    ,
    .drop_count (drop_count)
`endif
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] nib);
    valid_in = 1'b1;
    data_in  = nib;
    cyc();
    valid_in = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1; valid_in = 1'b0; pop = 1'b0; data_in = 4'h0;
    cyc(); cyc();
    reset = 1'b0;
    checks++;
    if (valid_out !== 1'b0 || fifo_full !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: got v=%b f=%b o=%b want 0 0 0", valid_out, fifo_full, overflow);
    end
    checks++;
    if (data_out_0 !== 4'h0 || data_out_1 !== 4'h0) begin
      errors++;
      $display("FAIL reset_data: got %h %h want 0 0", data_out_0, data_out_1);
    end
  endtask

  task automatic test_basic_split();
    logic [7:0] e;
    send(4'h3);
    checks++;
    if (valid_out !== 1'b0) begin
      errors++; $display("FAIL basic_half: valid_out=%b want 0", valid_out);
    end
    send(4'hA); exp_q.push_back({4'hA, 4'h3});
    e = exp_q.pop_front();
    checks++;
    if (valid_out !== 1'b1 || {data_out_1, data_out_0} !== e) begin
      errors++;
      $display("FAIL basic_pair: got v=%b %h want v=1 %h", valid_out, {data_out_1, data_out_0}, e);
    end
    pop = 1'b1; cyc(); pop = 1'b0;
    checks++;
    if (valid_out !== 1'b0) begin
      errors++; $display("FAIL basic_pop: valid_out=%b want 0", valid_out);
    end
  endtask

  task automatic test_gapped();
    logic [7:0] e;
    send(4'h5);
    repeat (3) cyc();
    checks++;
    if (valid_out !== 1'b0) begin
      errors++; $display("FAIL gap_idle: valid_out=%b want 0", valid_out);
    end
    send(4'h9); exp_q.push_back({4'h9, 4'h5});
    e = exp_q.pop_front();
    checks++;
    if (valid_out !== 1'b1 || {data_out_1, data_out_0} !== e) begin
      errors++;
      $display("FAIL gap_pair: got v=%b %h want v=1 %h", valid_out, {data_out_1, data_out_0}, e);
    end
    pop = 1'b1; cyc(); pop = 1'b0;
    cyc();
    checks++;
    if (valid_out !== 1'b0) begin
      errors++; $display("FAIL gap_extra: valid_out=%b want 0", valid_out);
    end
  endtask

  task automatic test_fill_overflow();
    logic [7:0] e;
    for (int i = 0; i < 5; i++) begin
      logic [3:0] a, b;
      a = 4'(2 * i + 1);
      b = 4'(2 * i + 2);
      send(a); send(b);
      if (i < 4) exp_q.push_back({b, a});
      if (i == 3) begin
        checks++;
        if (fifo_full !== 1'b1 || overflow !== 1'b0) begin
          errors++;
          $display("FAIL fill_full: got full=%b ovf=%b want 1 0", fifo_full, overflow);
        end
      end
    end
    checks++;
    if (overflow !== 1'b1 || fifo_full !== 1'b1) begin
      errors++;
      $display("FAIL fill_overflow: got ovf=%b full=%b want 1 1", overflow, fifo_full);
    end
`ifdef DEMUX_DROP_CNT_EN
    checks++;
    if (drop_count !== 8'd1) begin
      errors++; $display("FAIL fill_dropcnt: got %0d want 1", drop_count);
    end
`endif
    for (int k = 0; k < 4; k++) begin
      e = exp_q.pop_front();
      checks++;
      if (valid_out !== 1'b1 || {data_out_1, data_out_0} !== e) begin
        errors++;
        $display("FAIL fill_drain%0d: got v=%b %h want v=1 %h", k, valid_out,
                 {data_out_1, data_out_0}, e);
      end
      pop = 1'b1; cyc(); pop = 1'b0;
    end
    checks++;
    if (valid_out !== 1'b0 || fifo_full !== 1'b0 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL fill_after: got v=%b full=%b ovf=%b want 0 0 1", valid_out, fifo_full,
               overflow);
    end
    do_reset();
    checks++;
    if (overflow !== 1'b0) begin
      errors++; $display("FAIL fill_ovf_clear: ovf=%b want 0", overflow);
    end
  endtask

  task automatic test_full_simul_pop();
    logic [7:0] e;
    for (int i = 0; i < 4; i++) begin
      send(4'(i + 4)); send(4'(i + 8));
      exp_q.push_back({4'(i + 8), 4'(i + 4)});
    end
    send(4'hB);
    e = exp_q.pop_front();
    checks++;
    if ({data_out_1, data_out_0} !== e) begin
      errors++; $display("FAIL simul_head: got %h want %h", {data_out_1, data_out_0}, e);
    end
    valid_in = 1'b1; data_in = 4'hC; pop = 1'b1;
    cyc();
    valid_in = 1'b0; pop = 1'b0;
    exp_q.push_back({4'hC, 4'hB});
    checks++;
    if (overflow !== 1'b0 || fifo_full !== 1'b1) begin
      errors++;
      $display("FAIL simul_flags: got ovf=%b full=%b want 0 1", overflow, fifo_full);
    end
    for (int k = 0; k < 4; k++) begin
      e = exp_q.pop_front();
      checks++;
      if (valid_out !== 1'b1 || {data_out_1, data_out_0} !== e) begin
        errors++;
        $display("FAIL simul_drain%0d: got v=%b %h want v=1 %h", k, valid_out,
                 {data_out_1, data_out_0}, e);
      end
      pop = 1'b1; cyc(); pop = 1'b0;
    end
    checks++;
    if (valid_out !== 1'b0) begin
      errors++; $display("FAIL simul_empty: valid_out=%b want 0", valid_out);
    end
  endtask

  task automatic test_reset_mid_pair();
    logic [7:0] e;
    send(4'hE); send(4'hF);
    send(4'h7);
    do_reset();
    checks++;
    if (valid_out !== 1'b0 || data_out_0 !== 4'h0 || data_out_1 !== 4'h0) begin
      errors++;
      $display("FAIL midrst_empty: got v=%b %h%h want v=0 00", valid_out, data_out_1,
               data_out_0);
    end
    send(4'h1); send(4'h2); exp_q.push_back({4'h2, 4'h1});
    e = exp_q.pop_front();
    checks++;
    if (valid_out !== 1'b1 || {data_out_1, data_out_0} !== e) begin
      errors++;
      $display("FAIL midrst_pair: got v=%b %h want v=1 %h", valid_out, {data_out_1, data_out_0},
               e);
    end
    pop = 1'b1; cyc(); pop = 1'b0;
    checks++;
    if (valid_out !== 1'b0) begin
      errors++; $display("FAIL midrst_extra: valid_out=%b want 0", valid_out);
    end
  endtask

  task automatic test_pointer_wrap();
    logic [7:0] e;
    for (int i = 0; i < 10; i++) begin
      send(4'(i));
      if (valid_out === 1'b1) begin
        e = exp_q.pop_front();
        checks++;
        if ({data_out_1, data_out_0} !== e) begin
          errors++;
          $display("FAIL wrap_head%0d: got %h want %h", i, {data_out_1, data_out_0}, e);
        end
      end
      valid_in = 1'b1; data_in = 4'(15 - i); pop = 1'b1;
      cyc();
      valid_in = 1'b0; pop = 1'b0;
      exp_q.push_back({4'(15 - i), 4'(i)});
    end
    e = exp_q.pop_front();
    checks++;
    if (valid_out !== 1'b1 || {data_out_1, data_out_0} !== e || exp_q.size() != 0) begin
      errors++;
      $display("FAIL wrap_last: got v=%b %h want v=1 %h (left %0d)", valid_out,
               {data_out_1, data_out_0}, e, exp_q.size());
    end
    pop = 1'b1; cyc(); pop = 1'b0;
    checks++;
    if (valid_out !== 1'b0 || overflow !== 1'b0) begin
      errors++; $display("FAIL wrap_end: got v=%b ovf=%b want 0 0", valid_out, overflow);
    end
  endtask

  initial begin
    test_reset();
    test_basic_split();
    test_gapped();
    test_fill_overflow();
    test_full_simul_pop();
    test_reset_mid_pair();
    test_pointer_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/demux_estructural.md
Name: demux_estructural

Overview:
- Downstream consumer of the 2:1 alternating nibble mux. It takes the interleaved stream (lane 0, lane 1, lane 0, ...) and separates it back into two parallel lanes.
- Each completed lane-0/lane-1 pair is buffered in a small synchronous FIFO. The pair is presented with a valid/pop handshake to the next stage.

Parameters:
- DATA_WIDTH, 4, width of each lane nibble; matches the mux data path.
- FIFO_DEPTH, 4, number of buffered pairs; power of two, >= 2.
- PTR_W, $clog2(FIFO_DEPTH), pointer width; local, derived.

Ports:
- clk  input  1  single rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- data_in  input  DATA_WIDTH  interleaved nibble from the mux stage.
- valid_in  input  1  data_in valid this cycle.
- pop  input  1  consumer takes head pair when valid_out=1.
- data_out_0  output  DATA_WIDTH  lane-0 nibble of head pair.
- data_out_1  output  DATA_WIDTH  lane-1 nibble of head pair.
- valid_out  output  1  FIFO not empty.
- fifo_full  output  1  FIFO holds FIFO_DEPTH pairs.
- overflow  output  1  sticky: a completed pair was dropped.

Behaviour:
- Reset, sampled on the clk edge while reset=1:
  - lane state = LANE0; lane-0 holding register = 0.
  - FIFO pointers and count = 0.
  - data_out_0 = data_out_1 = 0; valid_out = 0; fifo_full = 0; overflow = 0.
- Lane state machine, two states:
  - LANE0 + valid_in=1: capture data_in into the holding register; go to LANE1.
  - LANE1 + valid_in=1: form the pair {lane1=data_in, lane0=holding}; push it; go to LANE0.
  - valid_in=0: hold state and holding register. Gaps mid-pair are legal.
- Lane assignment: the first valid nibble after reset is always lane 0.
- Reset mid-pair discards the half pair; the next valid nibble is lane 0.
- Latency: a pair completed on edge N gives valid_out=1 after edge N (visible in cycle N+1) when the FIFO was empty. No combinational path from data_in to the outputs.
- FIFO outputs:
  - Show-ahead: data_out_0/1 are the head entry; valid_out = (count != 0).
  - When empty, outputs hold their last value; they read 0 after reset.
- Pop:
  - pop with valid_out=1 removes the head on the edge.
  - pop with valid_out=0 is ignored; no underflow and no pointer change.
- Push when not full: write at wr_ptr; pointer wraps modulo FIFO_DEPTH.
- Push when full:
  - pop=1 in the same cycle: push accepted, count unchanged.
  - pop=0: pair dropped, overflow set. overflow stays set until reset.
- Push and pop in the same cycle when not full or empty: count unchanged, both pointers advance.
- fifo_full = (count == FIFO_DEPTH), registered.
- Count width is PTR_W+1 and never exceeds FIFO_DEPTH.

Optional Feature:
- Macro DEMUX_DROP_CNT_EN.
- Defined:
  - Adds output drop_count [7:0], reset to 0.
  - Increments on every dropped pair and saturates at 255.
  - overflow = (drop_count != 0).
- Undefined: port absent; overflow is a single sticky flop as above.

Decomposition:
- Package demux_pkg:
  - lane state encoding: LANE0=1'b0, LANE1=1'b1.
  - default DATA_WIDTH=4, FIFO_DEPTH=4.
  - DROP_CNT_MAX=8'd255.
- One sub-module: fifo_pair_sync, the parametric synchronous show-ahead FIFO of 2*DATA_WIDTH-bit entries.
- Lane state machine and overflow logic stay in demux_estructural.

Test Plan:
- Basic split:
  - Stimulus: reset, then valid_in=1 with data_in 4'h3, 4'hA.
  - Response: after second edge, valid_out=1, data_out_0=3, data_out_1=A.
  - Then pop=1 for one cycle: valid_out=0.
- Gapped input:
  - Stimulus: nibbles 5, idle 3 cycles, 9.
  - Response: single pair (5,9); no extra valid_out.
- Fill and overflow:
  - Stimulus: push 5 pairs (1,2),(3,4),(5,6),(7,8),(9,A) with pop=0.
  - Response: fifo_full=1 after the 4th pair; the 5th is dropped and overflow=1.
  - Pops then return the first 4 pairs in order.
  - With DEMUX_DROP_CNT_EN: drop_count=1.
- Full with simultaneous pop:
  - Stimulus: FIFO full; complete pair (B,C) with pop=1 on the same edge.
  - Response: no overflow; count stays 4; (B,C) emerges last.
- Reset mid-pair:
  - Stimulus: nibble 7 (lane 0), reset 1 cycle, then nibbles 1, 2.
  - Response: pair (1,2) only; 7 never appears; FIFO empty after reset.
- Pointer wrap:
  - Stimulus: 10 pairs with pop asserted each completion cycle.
  - Response: outputs match input order across pointer wrap; overflow stays 0.
